// File: rtl/mixcol_seq.sv
// mixcol_seq: column-serial AES MixColumns engine, COLS_PER_CYCLE columns per cycle.
// Define MIXCOL_SEQ_INV_EN to add the in_inv port and InvMixColumns support.
module mixcol_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_bypass,
`ifdef MIXCOL_SEQ_INV_EN
    input  logic         in_inv,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t       state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [127:0] st_q, st_d;
    logic [1:0]   idx;
`ifdef MIXCOL_SEQ_INV_EN
    logic         inv_q, inv_d;
`endif

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("mixcol_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Row 0 sits in the top byte of a column; r[i] uses rows rotated by i.
    function automatic logic [31:0] mix(input logic [31:0] c);
        logic [7:0] a [4];
        logic [7:0] x2 [4];
        logic [7:0] r [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = c[31-8*i -: 8];
            x2[i] = xt(a[i]);
        end
        for (int i = 0; i < 4; i++)
            r[i] = x2[i] ^ x2[2'(i+1)] ^ a[2'(i+1)] ^ a[2'(i+2)] ^ a[2'(i+3)];
        return {r[0], r[1], r[2], r[3]};
    endfunction

`ifdef MIXCOL_SEQ_INV_EN
    function automatic logic [31:0] imix(input logic [31:0] c);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] r [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = c[31-8*i -: 8];
            x2    = xt(a[i]);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        for (int i = 0; i < 4; i++)
            r[i] = me[i] ^ mb[2'(i+1)] ^ md[2'(i+2)] ^ m9[2'(i+3)];
        return {r[0], r[1], r[2], r[3]};
    endfunction
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        st_d    = st_q;
        idx     = '0;
`ifdef MIXCOL_SEQ_INV_EN
        inv_d   = inv_q;
`endif
        case (state_q)
            IDLE: if (in_valid) begin
                st_d    = in_data;
                cnt_d   = '0;
                state_d = in_bypass ? DONE : CALC;
`ifdef MIXCOL_SEQ_INV_EN
                inv_d   = in_inv;
`endif
            end
            CALC: begin
                for (int j = 0; j < COLS_PER_CYCLE; j++) begin
                    idx = cnt_q + 2'(j);
`ifdef MIXCOL_SEQ_INV_EN
                    st_d[{idx, 5'd0} +: 32] = inv_q ? imix(st_q[{idx, 5'd0} +: 32]) : mix(st_q[{idx, 5'd0} +: 32]);
`else
                    st_d[{idx, 5'd0} +: 32] = mix(st_q[{idx, 5'd0} +: 32]);
`endif
                end
                cnt_d   = cnt_q + 2'(COLS_PER_CYCLE);
                state_d = ({1'b0, cnt_q} + 3'(COLS_PER_CYCLE) == 3'd4) ? DONE : CALC;
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            st_q    <= '0;
`ifdef MIXCOL_SEQ_INV_EN
            inv_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            st_q    <= st_d;
`ifdef MIXCOL_SEQ_INV_EN
            inv_q   <= inv_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = st_q;
endmodule

// File: tb/tb_mixcol_seq.sv
// tb_mixcol_seq: directed checks of mixcol_seq with COLS_PER_CYCLE = 1, 2 and 4 side by side.
module tb_mixcol_seq;
    localparam logic [127:0] FWD_IN  = 128'h2d26314c_01010101_f20a225c_db135345;
    localparam logic [127:0] FWD_OUT = 128'h4d7ebdf8_01010101_9fdc589d_8e4da1bc;
    localparam logic [127:0] BYP_IN  = 128'h0123456789abcdef_fedcba9876543210;
    localparam logic [127:0] ID_IN   = 128'hd4d4d4d5_c6c6c6c6_d4d4d4d5_c6c6c6c6;
    localparam logic [127:0] ID_OUT  = 128'hd5d5d7d6_c6c6c6c6_d5d5d7d6_c6c6c6c6;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_bypass = 1'b0;
    logic         out_ready = 1'b1;
    logic [127:0] in_data = '0;
`ifdef MIXCOL_SEQ_INV_EN
    logic         in_inv = 1'b0;
`endif
    logic [2:0]   ir, ov, bz;
    logic [127:0] od [3];

    int           n_tests = 0;
    int           n_fail = 0;
    int           lat [3];
    logic [127:0] got [3];
    int           busy_n;
    logic [127:0] snap [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mixcol_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (ir[g]),
            .in_data   (in_data),
            .in_bypass (in_bypass),
`ifdef MIXCOL_SEQ_INV_EN
            .in_inv    (in_inv),
`endif
            .out_valid (ov[g]),
            .out_ready (out_ready),
            .out_data  (od[g]),
            .busy      (bz[g])
        );
    end

    task automatic chk(input string tag, input logic [127:0] got_v, input logic [127:0] exp_v);
        n_tests++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got_v, exp_v);
        end
    endtask

    // Latency is counted in edges after the accepting edge; sample 0 is just after it.
    task automatic send(input logic [127:0] d, input logic byp);
        @(negedge clk);
        in_data   = d;
        in_bypass = byp;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        chk("accept_ready", 128'(ir), 128'h7);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        busy_n   = 0;
        for (int k = 0; k < 3; k++) begin
            lat[k] = -1;
            got[k] = '0;
        end
        for (int e = 0; e < 8; e++) begin
            if (e > 0) begin
                @(posedge clk);
                #1;
            end
            busy_n += int'(bz[0]);
            for (int k = 0; k < 3; k++)
                if (ov[k] && lat[k] < 0) begin
                    lat[k] = e;
                    got[k] = od[k];
                end
        end
    endtask

    task automatic xfer(input string tag, input logic [127:0] d, input logic byp, input logic [127:0] exp_v);
        send(d, byp);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_data_c%0d", tag, 1 << k), got[k], exp_v);
            chk($sformatf("%s_lat_c%0d", tag, 1 << k), 128'(lat[k]), byp ? 128'd0 : 128'(4 >> k));
        end
        chk($sformatf("%s_busy_c1", tag), 128'(busy_n), byp ? 128'd1 : 128'd5);
    endtask

    initial begin
        #1;
        chk("rst_in_ready", 128'(ir), 128'h7);
        chk("rst_out_valid", 128'(ov), 128'h0);
        chk("rst_busy", 128'(bz), 128'h0);
        chk("rst_out_data", od[0] | od[1] | od[2], 128'h0);
        @(negedge clk);
        rst_n = 1'b1;

        xfer("fwd", FWD_IN, 1'b0, FWD_OUT);
        xfer("byp", BYP_IN, 1'b1, BYP_IN);
        xfer("ident", ID_IN, 1'b0, ID_OUT);

        // Backpressure: results must hold while out_ready is low.
        @(negedge clk);
        in_data   = FWD_IN;
        in_bypass = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) snap[k] = od[k];
        chk("bp_data_c1", snap[0], FWD_OUT);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid = (c == 3);
            in_data  = (c == 3) ? BYP_IN : FWD_IN;
            chk("bp_out_valid", 128'(ov), 128'h7);
            chk("bp_in_ready", 128'(ir), 128'h0);
            for (int k = 0; k < 3; k++) chk($sformatf("bp_hold_c%0d", 1 << k), od[k], FWD_OUT);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", 128'(ov), 128'h0);
        chk("bp_release_ready", 128'(ir), 128'h7);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_no_accept_busy", 128'(bz), 128'h0);

        // Asynchronous reset in the middle of a computation.
        @(negedge clk);
        in_data   = FWD_IN;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("pre_rst_valid_c4", 128'(ov[2]), 128'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 128'(ov), 128'h0);
        chk("mid_rst_in_ready", 128'(ir), 128'h7);
        chk("mid_rst_busy", 128'(bz), 128'h0);
        for (int k = 0; k < 3; k++) chk($sformatf("mid_rst_data_c%0d", 1 << k), od[k], 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        xfer("post_rst", FWD_IN, 1'b0, FWD_OUT);

`ifdef MIXCOL_SEQ_INV_EN
        in_inv = 1'b1;
        xfer("inv", FWD_OUT, 1'b0, FWD_IN);
        xfer("inv_byp", BYP_IN, 1'b1, BYP_IN);
        for (int t = 0; t < 4; t++) begin
            logic [127:0] d, f;
            d = {$urandom, $urandom, $urandom, $urandom};
            in_inv = 1'b0;
            send(d, 1'b0);
            f = got[0];
            chk("rt_fwd_c2", got[1], f);
            chk("rt_fwd_c4", got[2], f);
            in_inv = 1'b1;
            xfer("rt_inv", f, 1'b0, d);
        end
        in_inv = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
